// File: rtl/block_memory_pkg.sv
// Shared constants for the cache / main-memory boundary: word and line geometry
// and the main-memory FSM state encoding.
package block_memory_pkg;

  localparam int WORD_W     = 16;
  localparam int LINE_WORDS = 4;
  localparam int LINE_W     = 64;
  localparam int OFFSET_W   = 2;

  localparam int CNT_W      = 4;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/block_mem_array.sv
// DEPTH x 16-bit storage with one synchronous word write port and a
// combinational 4-word line read port.
module block_mem_array
  import block_memory_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [IDX_W-1:0]           widx,
  input  logic [WORD_W-1:0]          wdata,
  input  logic [IDX_W-OFFSET_W-1:0]  line_idx,
  output logic [LINE_W-1:0]          line
);

  logic [WORD_W-1:0] mem [DEPTH];

  // NOTE: storage has no reset; contents deliberately survive a reset.
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  always_comb begin
    line = '0;
    for (int w = 0; w < LINE_WORDS; w++)
      line[w*WORD_W +: WORD_W] = mem[{line_idx, OFFSET_W'(w)}];
  end

endmodule

// File: rtl/block_memory.sv
// Main-memory stage behind the 2-way cache: fixed-latency line reads and word
// writes, one request at a time. Define BLOCK_MEM_POSTED_WRITE_EN for 1-cycle posted writes.
module block_memory
  import block_memory_pkg::*;
#(
  parameter int LATENCY = 6,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              readM,
  input  logic              writeM,
  input  logic [WORD_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata,
  output logic              ready,
  output logic              done
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  count;
  logic              is_write;
  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] wdata_q;

  logic [IDX_W-1:0]  req_idx;
  logic              last_busy;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [WORD_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_line;

  // Out-of-range addresses simply wrap onto the array.
  assign req_idx   = IDX_W'(address % ADDR_W'(DEPTH));
  assign last_busy = (state == ST_BUSY) && (count == CNT_W'(1));

  assign ready = (state == ST_IDLE);
  assign done  = (state == ST_DONE);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    mem_we    = last_busy && is_write;
    mem_widx  = idx_q;
    mem_wdata = wdata_q;
`ifdef BLOCK_MEM_POSTED_WRITE_EN
    if ((state == ST_IDLE) && writeM) begin
      mem_we    = 1'b1;
      mem_widx  = req_idx;
      mem_wdata = wdata;
    end
`endif
  end

  block_mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk      (clk),
    .we       (mem_we),
    .widx     (mem_widx),
    .wdata    (mem_wdata),
    .line_idx (idx_q[IDX_W-1:OFFSET_W]),
    .line     (mem_line)
  );

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      is_write <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      rdata    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (writeM) begin
            idx_q    <= req_idx;
            wdata_q  <= wdata;
            is_write <= 1'b1;
`ifdef BLOCK_MEM_POSTED_WRITE_EN
            state    <= ST_DONE;
`else
            count    <= CNT_INIT;
            state    <= ST_BUSY;
`endif
          end else if (readM) begin
            idx_q    <= req_idx;
            is_write <= 1'b0;
            count    <= CNT_INIT;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          count <= count - CNT_W'(1);
          if (last_busy) begin
            state <= ST_DONE;
            if (!is_write) rdata <= mem_line;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_memory.sv
// Self-checking bench for block_memory: directed scenarios plus randomized
// traffic against a word-array reference model of main memory.
module tb_block_memory;

  localparam int LATENCY = 6;
  localparam int DEPTH   = 256;
  localparam int ADDR_W  = 16;
`ifdef BLOCK_MEM_POSTED_WRITE_EN
  localparam int WR_LAT = 1;
`else
  localparam int WR_LAT = LATENCY;
`endif
  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address = '0;
  logic        readM = 1'b0;
  logic        writeM = 1'b0;
  logic [15:0] wdata = '0;
  logic [63:0] rdata;
  logic        ready;
  logic        done;

  int errors = 0;
  int checks = 0;

  logic [15:0] model_mem   [DEPTH];
  bit          model_valid [DEPTH];
  logic [63:0] exp_rdata = '0;
  logic [63:0] exp_mask  = '1;

  block_memory #(
    .LATENCY (LATENCY),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .address (address),
    .readM   (readM),
    .writeM  (writeM),
    .wdata   (wdata),
    .rdata   (rdata),
    .ready   (ready),
    .done    (done)
  );

  always #5 clk = ~clk;

  // One cache-style request: hold it until done, then drop it.
  task automatic do_req(input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wd, input bit scramble);
    int cyc;
    int lat;
    int idx;
    int base;
    cyc = 0;
    while (ready !== 1'b1 && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_wait addr=%h: ready=%b required 1", addr, ready);
    end
    lat = wr ? WR_LAT : LATENCY;
    idx = int'(addr) % DEPTH;
    readM = rd; writeM = wr; address = addr; wdata = wd;
    if (wr) begin
      model_mem[idx]   = wd;
      model_valid[idx] = 1'b1;
    end else begin
      base = idx & ~3;
      for (int w = 0; w < 4; w++) begin
        exp_rdata[w*16 +: 16] = model_mem[base + w];
        exp_mask[w*16 +: 16]  = model_valid[base + w] ? 16'hFFFF : 16'h0000;
      end
    end
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (done !== 1'b1) begin
        checks++;
        if (ready !== 1'b0) begin
          errors++;
          $display("FAIL busy_ready addr=%h cyc=%0d: ready=%b required 0", addr, cyc, ready);
        end
        if (scramble && cyc == 2) begin
          address = 16'h0020; wdata = 16'hFFFF;
        end
      end
    end while (done !== 1'b1 && cyc < TIMEOUT);
    readM = 1'b0; writeM = 1'b0;
    checks++;
    if (cyc != lat || done !== 1'b1) begin
      errors++;
      $display("FAIL latency addr=%h wr=%b: done after %0d cycles (done=%b) required %0d",
               addr, wr, cyc, done, lat);
    end
    checks++;
    if ((rdata & exp_mask) !== (exp_rdata & exp_mask)) begin
      errors++;
      $display("FAIL rdata addr=%h wr=%b: got %h required %h (mask %h)",
               addr, wr, rdata, exp_rdata, exp_mask);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || rdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_state: ready=%b done=%b rdata=%h required 1 0 0", ready, done, rdata);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_done cyc=%0d: done=%b required 0", i, done);
      end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++)
      do_req(1'b0, 1'b1, 16'(i), 16'($urandom), 1'b0);
  endtask

  task automatic test_write_read();
    do_req(1'b0, 1'b1, 16'h0005, 16'hBEEF, 1'b0);
    do_req(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0);
    checks++;
    if (rdata[31:16] !== 16'hBEEF) begin
      errors++;
      $display("FAIL write_read word1: got %h required beef", rdata[31:16]);
    end
  endtask

  task automatic test_priority_busy();
    do_req(1'b1, 1'b1, 16'h0010, 16'h1234, 1'b1);
    do_req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    checks++;
    if (rdata[15:0] !== 16'h1234) begin
      errors++;
      $display("FAIL priority word0: got %h required 1234", rdata[15:0]);
    end
    do_req(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
  endtask

  task automatic test_wrap();
    do_req(1'b0, 1'b1, 16'h0103, 16'hA5A5, 1'b0);
    do_req(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    checks++;
    if (rdata[63:48] !== 16'hA5A5) begin
      errors++;
      $display("FAIL wrap word3: got %h required a5a5", rdata[63:48]);
    end
  endtask

  task automatic abort_after(input bit rd, input bit wr, input logic [15:0] addr,
                             input logic [15:0] wd);
    @(negedge clk);
    readM = rd; writeM = wr; address = addr; wdata = wd;
    @(posedge clk);
    repeat (3) @(negedge clk);
    reset = 1'b1; readM = 1'b0; writeM = 1'b0;
    #1;
    exp_rdata = '0; exp_mask = '1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || rdata !== 64'h0) begin
      errors++;
      $display("FAIL midop_reset addr=%h: ready=%b done=%b rdata=%h required 1 0 0",
               addr, ready, done, rdata);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || ready !== 1'b1) begin
        errors++;
        $display("FAIL midop_quiet cyc=%0d: done=%b ready=%b required 0 1", i, done, ready);
      end
    end
  endtask

  task automatic test_reset_midop();
    abort_after(1'b1, 1'b0, 16'h0004, 16'h0000);
`ifndef BLOCK_MEM_POSTED_WRITE_EN
    // Aborted write must leave the old word in place.
    abort_after(1'b0, 1'b1, 16'h0021, 16'hDEAD);
    do_req(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
`endif
  endtask

  task automatic test_posted();
    do_req(1'b0, 1'b1, 16'h0008, 16'h0F0F, 1'b0);
    do_req(1'b1, 1'b0, 16'h0008, 16'h0000, 1'b0);
    checks++;
    if (rdata[15:0] !== 16'h0F0F) begin
      errors++;
      $display("FAIL posted word0: got %h required 0f0f", rdata[15:0]);
    end
  endtask

  task automatic test_random();
    int op;
    for (int n = 0; n < 80; n++) begin
      op = int'($urandom_range(0, 2));
      do_req(op != 1, op != 0, 16'($urandom), 16'($urandom), bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_valid[i] = 1'b0;
    test_reset();
    test_fill();
    test_write_read();
    test_priority_busy();
    test_wrap();
    test_reset_midop();
    test_posted();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
